// File: rtl/gf_mul_pkg.sv
// gf_mul_pkg: shared widths, drain latency and FSM encoding for the GF(2^m) operand feeder
package gf_mul_pkg;
    localparam int M = 32;
    localparam int DRAIN_LAT = 31;
    localparam int CNT_W = 6;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;
endpackage

// File: rtl/gf_operand_feeder_if.sv
// gf_operand_feeder_if: operand input, array-side and product output signals of the feeder
interface gf_operand_feeder_if #(parameter int M = 32);
    logic       in_valid, in_ready;
    logic [1:M] in_a, in_b;
    logic [1:M] arr_a;
    logic       arr_b_bit, arr_valid, arr_start, arr_last;
    logic [1:M] arr_res;
    logic       out_valid, out_ready;
    logic [1:M] out_c;
    modport slave (
        input  in_valid, in_a, in_b, arr_res, out_ready,
        output in_ready, arr_a, arr_b_bit, arr_valid, arr_start, arr_last, out_valid, out_c
    );
    modport master (
        output in_valid, in_a, in_b, arr_res, out_ready,
        input  in_ready, arr_a, arr_b_bit, arr_valid, arr_start, arr_last, out_valid, out_c
    );
endinterface

// File: rtl/gf_bserial_shift.sv
// gf_bserial_shift: parallel-load shift register emitting bit 1 (MSB) first
module gf_bserial_shift #(parameter int M = 32) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       shift,
    input  logic [1:M] d,
    output logic       q
);
    logic [1:M] sr;
    always_ff @(posedge clk or negedge rst)
        if (!rst) sr <= '0;
        else if (load) sr <= d;
        else if (shift) sr <= {sr[2:M], 1'b0};
    assign q = sr[1];
endmodule

// File: rtl/gf_operand_feeder.sv
// gf_operand_feeder: accepts (a,b), streams b MSB-first into the systolic array, waits the drain, holds the product
module gf_operand_feeder #(
    parameter int M         = gf_mul_pkg::M,
    parameter int DRAIN_LAT = gf_mul_pkg::DRAIN_LAT,
    parameter int CNT_W     = gf_mul_pkg::CNT_W
) (
    input logic                clk,
    input logic                rst,
    gf_operand_feeder_if.slave bus,
    output logic               busy
);
    import gf_mul_pkg::*;
    state_t           state, state_nx;
    logic [CNT_W-1:0] bit_cnt, lat_cnt;
    logic [1:M]       a_reg;
    logic             accept, feed_end, drain_end, b_bit;
    assign accept    = bus.in_valid && bus.in_ready;
    assign feed_end  = state == ST_FEED && bit_cnt == CNT_W'(M - 1);
    assign drain_end = state == ST_DRAIN && lat_cnt == CNT_W'(DRAIN_LAT - 1);
    gf_bserial_shift #(.M(M)) u_shift (
        .clk(clk), .rst(rst), .load(accept), .shift(state == ST_FEED), .d(bus.in_b), .q(b_bit)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE:  state_nx = accept ? ST_FEED : ST_IDLE;
            ST_FEED:  state_nx = feed_end ? ST_DRAIN : ST_FEED;
            ST_DRAIN: state_nx = drain_end ? ST_HOLD : ST_DRAIN;
            ST_HOLD:  state_nx = !bus.out_ready ? ST_HOLD : bus.in_valid ? ST_FEED : ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end
    // in_ready is gated by rst so nothing is accepted while reset is asserted
    always_comb begin
        bus.in_ready  = rst && (state == ST_IDLE || (state == ST_HOLD && bus.out_ready));
        bus.arr_valid = state == ST_FEED;
        bus.arr_start = state == ST_FEED && bit_cnt == '0;
        bus.arr_last  = feed_end;
        bus.arr_b_bit = state == ST_FEED && b_bit;
        bus.out_valid = state == ST_HOLD;
        bus.arr_a     = a_reg;
        busy          = state != ST_IDLE;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            a_reg     <= '0;
            bit_cnt   <= '0;
            lat_cnt   <= '0;
            bus.out_c <= '0;
        end else begin
            if (accept) a_reg <= bus.in_a;
            if (accept) bit_cnt <= '0;
            else if (state == ST_FEED) bit_cnt <= bit_cnt + 1'b1;
            if (feed_end) lat_cnt <= '0;
            else if (state == ST_DRAIN) lat_cnt <= lat_cnt + 1'b1;
            if (drain_end) bus.out_c <= bus.arr_res;
        end
endmodule

// File: tb/tb_gf_operand_feeder.sv
// tb_gf_operand_feeder: directed checks of serial ordering, capture timing, backpressure, back-to-back and reset abort
module tb_gf_operand_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;
    gf_operand_feeder_if #(.M(32)) bus();
    gf_operand_feeder dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        logic [3:0] obs;
        bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.arr_res = '0; bus.out_ready = 0;
        #1;
        obs = {bus.in_ready, bus.arr_valid, bus.out_valid, busy};
        n_cmp++; if (obs !== 4'b0000) begin n_err++; $display("FAIL reset_held got=%b exp=0000", obs); end
        repeat (2) @(posedge clk);
        #1 rst = 1;
        #1;
        obs = {bus.in_ready, bus.arr_valid, bus.out_valid, busy};
        n_cmp++; if (obs !== 4'b1000) begin n_err++; $display("FAIL reset_idle got=%b exp=1000", obs); end
        n_cmp++; if (bus.arr_a !== 32'h0) begin n_err++; $display("FAIL reset_arr_a got=%h exp=0", bus.arr_a); end
        n_cmp++; if (bus.out_c !== 32'h0) begin n_err++; $display("FAIL reset_out_c got=%h exp=0", bus.out_c); end
        tick;
    endtask
    task automatic test_serial_capture;
        logic [6:0] obs, exp;
        bus.in_a = 32'h12345678; bus.in_b = 32'h80000001; bus.in_valid = 1;
        tick;
        bus.in_valid = 0; bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'h0;
        for (int k = 1; k <= 63; k++) begin
            exp = {k <= 32, k == 1, k == 32, k == 1 || k == 32, 1'b0, 1'b0, 1'b1};
            obs = {bus.arr_valid, bus.arr_start, bus.arr_last, bus.arr_b_bit, bus.in_ready, bus.out_valid, busy};
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL serial_cyc%0d got=%b exp=%b", k, obs, exp); end
            n_cmp++; if (bus.arr_a !== 32'h12345678) begin n_err++; $display("FAIL arr_a_cyc%0d got=%h exp=12345678", k, bus.arr_a); end
            bus.arr_res = (k == 63) ? 32'hDEADBEEF : 32'h0;
            tick;
        end
        bus.arr_res = '0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL capture_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.out_c !== 32'hDEADBEEF) begin n_err++; $display("FAIL capture_out_c got=%h exp=deadbeef", bus.out_c); end
    endtask
    task automatic test_backpressure;
        logic [3:0] obs;
        bus.out_ready = 0; bus.in_valid = 1; bus.in_b = 32'h0000FFFF;
        for (int i = 0; i < 20; i++) begin
            bus.arr_res = i[0] ? 32'hFFFFFFFF : 32'h00001234;
            tick;
            obs = {bus.out_valid, bus.in_ready, bus.arr_valid, busy};
            n_cmp++; if (obs !== 4'b1001) begin n_err++; $display("FAIL hold_ctl_%0d got=%b exp=1001", i, obs); end
            n_cmp++; if (bus.out_c !== 32'hDEADBEEF) begin n_err++; $display("FAIL hold_out_c_%0d got=%h exp=deadbeef", i, bus.out_c); end
        end
        bus.arr_res = '0;
    endtask
    task automatic test_back_to_back;
        logic [3:0] obs, exp;
        bus.in_a = 32'h0F0F0F0F; bus.in_b = 32'hFFFFFFFF; bus.in_valid = 1; bus.out_ready = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
        tick;
        bus.in_valid = 0; bus.out_ready = 0;
        for (int k = 1; k <= 32; k++) begin
            exp = {1'b1, k == 1, 1'b1, 1'b0};
            obs = {bus.arr_valid, bus.arr_start, bus.arr_b_bit, bus.out_valid};
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_feed_cyc%0d got=%b exp=%b", k, obs, exp); end
            tick;
        end
        for (int k = 33; k <= 63; k++) begin
            bus.arr_res = (k == 63) ? 32'hA5A55A5A : 32'h0;
            tick;
        end
        bus.arr_res = '0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", bus.out_valid); end
        n_cmp++; if (bus.out_c !== 32'hA5A55A5A) begin n_err++; $display("FAIL b2b_out_c got=%h exp=a5a55a5a", bus.out_c); end
        n_cmp++; if (bus.arr_a !== 32'h0F0F0F0F) begin n_err++; $display("FAIL b2b_arr_a got=%h exp=0f0f0f0f", bus.arr_a); end
        bus.out_ready = 1;
        tick;
        bus.out_ready = 0;
        obs = {bus.out_valid, bus.in_ready, busy, bus.arr_valid};
        n_cmp++; if (obs !== 4'b0100) begin n_err++; $display("FAIL drain_to_idle got=%b exp=0100", obs); end
    endtask
    task automatic test_reset_mid_feed;
        logic [6:0] obs;
        logic       seen;
        bus.in_a = 32'hCAFEF00D; bus.in_b = 32'h55555555; bus.in_valid = 1;
        tick;
        bus.in_valid = 0;
        repeat (10) tick;
        n_cmp++; if (bus.arr_valid !== 1'b1) begin n_err++; $display("FAIL midfeed_active got=%b exp=1", bus.arr_valid); end
        rst = 0;
        #1;
        obs = {bus.in_ready, bus.arr_valid, bus.arr_b_bit, bus.arr_start, bus.arr_last, bus.out_valid, busy};
        n_cmp++; if (obs !== 7'b0) begin n_err++; $display("FAIL midfeed_reset_ctl got=%b exp=0000000", obs); end
        n_cmp++; if (bus.arr_a !== 32'h0) begin n_err++; $display("FAIL midfeed_reset_arr_a got=%h exp=0", bus.arr_a); end
        n_cmp++; if (bus.out_c !== 32'h0) begin n_err++; $display("FAIL midfeed_reset_out_c got=%h exp=0", bus.out_c); end
        tick; tick;
        rst = 1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
        bus.arr_res = 32'hFFFFFFFF; bus.out_ready = 1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            seen = seen | bus.out_valid | busy;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL aborted_result got=%b exp=0", seen); end
    endtask
    initial begin
        test_reset;
        test_serial_capture;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_feed;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
